level_pwm: RTL and testbench
============================

LEVEL_PWM -- requirements
Module: level_pwm

Interface
REQ-001 Parameter PRESCALE, default 4, clock cycles per PWM slot; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 level  input  3  requested duty level 0..7, driven by the upstream 3-bit up/down counter.
REQ-005 level_valid  input  1  high when level is meaningful; sampled only at period boundaries and in IDLE.
REQ-006 pwm_out  output  1  PWM waveform, 8 slots per period.
REQ-007 period_tick  output  1  one-cycle pulse at each PWM period start; usable as the upstream counter advance enable.
REQ-008 dir_up  output  1  registered direction of the last non-equal duty change (1 = rising).
REQ-009 peak  output  1  one-cycle pulse when the duty turns from rising to falling.
REQ-010 trough  output  1  one-cycle pulse when the duty turns from falling to rising.

Function
REQ-011 The FSM SHALL have two states: IDLE and RUN.
REQ-012 In IDLE, on a clock edge with level_valid=1: go to RUN, duty<=level, slot<=0, pre<=0; no peak or trough pulse; dir_up unchanged.
REQ-013 In RUN, the prescaler pre SHALL count 0..PRESCALE-1 and wrap; slot SHALL increment mod 8 on each pre wrap.
REQ-014 pwm_out SHALL equal (state==RUN && slot<duty): duty 0 is always low, duty 7 is high for 7 of 8 slots, and IDLE is always low.
REQ-015 Boundary cycle B: state==RUN, slot==7, pre==PRESCALE-1.
REQ-016 On the edge ending B with level_valid=1: duty<=level, slot<=0, pre<=0, stay in RUN.
REQ-017 On the edge ending B with level_valid=0: go to IDLE, duty<=0.
REQ-018 level and level_valid values outside B (in RUN) SHALL be ignored; a mid-period change never alters the current period.
REQ-019 period_tick SHALL be registered: high for exactly the one cycle following the IDLE->RUN edge and each B edge that stays in RUN.
REQ-020 At a B latch with new>old duty: dir_up<=1; trough pulses if dir_up was 0.
REQ-021 At a B latch with new<old duty: dir_up<=0; peak pulses if dir_up was 1.
REQ-022 At a B latch with new==old duty: dir_up is held, and no peak or trough pulse occurs.
REQ-023 peak and trough SHALL be registered and coincide with period_tick; they are never both high.
REQ-024 Duty comparisons SHALL be unsigned 3-bit; slot SHALL be 3-bit and wrap 7->0; pre width SHALL be 8 bits.

Reset
REQ-025 Asserting reset SHALL immediately, with no clock, force state=IDLE, duty=0, slot=0, pre=0, pwm_out=0, period_tick=0, peak=0, trough=0, dir_up=1.
REQ-026 Reset asserted mid-period SHALL abort the period; after release, operation restarts per REQ-012.

Structure
REQ-027 A shared package count_pkg SHALL hold the state enum (IDLE, RUN), the constant PWM_SLOTS=8 and the level width 3.
REQ-028 The prescaler plus slot counter SHALL be one sub-module, slot_timer, with ports clk, reset, run, slot[2:0], last (=B).
REQ-029 level_pwm SHALL contain the FSM, the duty/direction registers and the output decode.

Verification (PRESCALE=2, period = 16 clocks)
REQ-030 level=3 held, level_valid=1 -> pwm_out high 6 clocks, then low 10, every period; period_tick every 16 clocks.
REQ-031 level=0, then level=7 at the next boundary -> one period fully low, then 14 high and 2 low.
REQ-032 Sequence 5,6,7,6,5 at successive boundaries -> dir_up 1,1,0,0; exactly one peak, at the tick that latches 6 after 7; no trough.
REQ-033 Sequence 2,1,1,2 -> dir_up goes 0, is held through the equal step, then returns to 1; exactly one trough, at the 1->2 tick.
REQ-034 level_valid deasserted mid-period -> current period completes unchanged, then IDLE with pwm_out=0 and no further period_tick.
REQ-035 reset pulsed at slot 2 with duty=5 -> pwm_out, period_tick, peak and trough are 0 in the same timestep and dir_up=1.

Source files
------------

// File: rtl/count_pkg.sv
// count_pkg: shared FSM state, slot count and field widths for the level PWM.
package count_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam int PWM_SLOTS = 8;
    localparam int LEVEL_W   = 3;
    localparam int SLOT_W    = 3;
    localparam int PRE_W     = 8;
endpackage

// File: rtl/slot_timer.sv
// slot_timer: prescaler plus slot counter that paces one 8-slot PWM period.
module slot_timer
    import count_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [SLOT_W-1:0] slot,
    output logic              last
);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    logic [PRE_W-1:0] pre;
    logic             wrap;
    assign wrap = pre == PRE_MAX;
    assign last = run && wrap && slot == SLOT_W'(PWM_SLOTS - 1);
    // Held at zero while idle so a start always begins at slot 0, pre 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre  <= '0;
            slot <= '0;
        end else if (!run) begin
            pre  <= '0;
            slot <= '0;
        end else begin
            pre  <= wrap ? '0 : pre + 1'b1;
            slot <= wrap ? slot + 1'b1 : slot;
        end
    end
endmodule

// File: rtl/level_pwm.sv
// level_pwm: 8-slot PWM whose duty is latched from level at period boundaries,
// with direction tracking and peak/trough pulses on duty turning points.
module level_pwm
    import count_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] level,
    input  logic               level_valid,
    output logic               pwm_out,
    output logic               period_tick,
    output logic               dir_up,
    output logic               peak,
    output logic               trough
);
    state_t             state;
    logic [LEVEL_W-1:0] duty;
    logic [SLOT_W-1:0]  slot;
    logic               last;
    logic               run;
    assign run     = state == RUN;
    assign pwm_out = run && slot < duty;
    slot_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .slot  (slot),
        .last  (last)
    );
    // Inputs only matter in IDLE or on the final cycle of a period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            duty        <= '0;
            dir_up      <= 1'b1;
            period_tick <= 1'b0;
            peak        <= 1'b0;
            trough      <= 1'b0;
        end else begin
            period_tick <= 1'b0;
            peak        <= 1'b0;
            trough      <= 1'b0;
            if (state == IDLE) begin
                if (level_valid) begin
                    state       <= RUN;
                    duty        <= level;
                    period_tick <= 1'b1;
                end
            end else if (last) begin
                if (!level_valid) begin
                    state <= IDLE;
                    duty  <= '0;
                end else begin
                    duty        <= level;
                    period_tick <= 1'b1;
                    if (level > duty) begin
                        dir_up <= 1'b1;
                        trough <= !dir_up;
                    end else if (level < duty) begin
                        dir_up <= 1'b0;
                        peak   <= dir_up;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_level_pwm.sv
// tb_level_pwm: period-level reference model feeding a scoreboard checked on each period_tick.
module tb_level_pwm;
    localparam int P = 2;
    localparam int PERIOD = 8 * P;

    typedef struct {
        int duty;
        bit dir;
        bit pk;
        bit tr;
    } rec_t;

    logic       clk;
    logic       reset;
    logic [2:0] level;
    logic       level_valid;
    logic       pwm_out, period_tick, dir_up, peak, trough;

    int   checks = 0;
    int   failures = 0;
    rec_t q[$];
    rec_t cur;
    int   k;
    int   m_duty;
    bit   m_dir;

    level_pwm #(.PRESCALE(P)) dut (
        .clk         (clk),
        .reset       (reset),
        .level       (level),
        .level_valid (level_valid),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .dir_up      (dir_up),
        .peak        (peak),
        .trough      (trough)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int lv, input int v);
        level = 3'(lv);
        level_valid = 1'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int lv);
        step(lv, 1);
        q.push_back('{duty: lv, dir: m_dir, pk: 1'b0, tr: 1'b0});
        m_duty = lv;
    endtask

    // One full period of ignored noise, then the boundary value that decides the next one.
    task automatic period(input int lv, input bit v);
        bit pk, tr;
        repeat (PERIOD - 1) step(int'($urandom_range(7)), int'($urandom_range(1)));
        step(lv, int'(v));
        if (v) begin
            pk = (lv < m_duty) && m_dir;
            tr = (lv > m_duty) && !m_dir;
            if (lv > m_duty) m_dir = 1'b1;
            else if (lv < m_duty) m_dir = 1'b0;
            q.push_back('{duty: lv, dir: m_dir, pk: pk, tr: tr});
            m_duty = lv;
        end else begin
            m_duty = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(int'($urandom_range(7)), 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            cur = '{duty: 0, dir: 1'b1, pk: 1'b0, tr: 1'b0};
            k = PERIOD;
        end else begin
            if (period_tick) begin
                chk("tick_has_record", int'(q.size() > 0), 1);
                if (q.size() > 0) cur = q.pop_front();
                k = 0;
                chk("peak", int'(peak), int'(cur.pk));
                chk("trough", int'(trough), int'(cur.tr));
            end else begin
                chk("peak_idle", int'(peak), 0);
                chk("trough_idle", int'(trough), 0);
            end
            chk("pwm_out", int'(pwm_out), int'(k < P * cur.duty));
            chk("dir_up", int'(dir_up), int'(cur.dir));
            if (k < 100000) k++;
        end
    end

    initial begin
        m_duty = 0;
        m_dir = 1'b1;
        reset = 1'b1;
        level = 3'd0;
        level_valid = 1'b0;
        #2;
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_tick", int'(period_tick), 0);
        chk("rst_peak", int'(peak), 0);
        chk("rst_trough", int'(trough), 0);
        chk("rst_dir", int'(dir_up), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);
        start(3); period(3, 1); period(3, 1); period(0, 0); idle(20);
        start(0); period(7, 1); period(7, 0); idle(5);
        start(5); period(6, 1); period(7, 1); period(6, 1); period(5, 1); period(0, 0); idle(4);
        start(2); period(1, 1); period(1, 1); period(2, 1); period(2, 0); idle(4);
        for (int r = 0; r < 6; r++) begin
            start(int'($urandom_range(7)));
            repeat ($urandom_range(1, 4)) period(int'($urandom_range(7)), 1'b1);
            period(int'($urandom_range(7)), 1'b0);
            idle(int'($urandom_range(1, 10)));
        end
        start(7); period(5, 1);
        repeat (4) step(int'($urandom_range(7)), int'($urandom_range(1)));
        chk("pre_reset_pwm", int'(pwm_out), 1);
        chk("pre_reset_dir", int'(dir_up), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_pwm", int'(pwm_out), 0);
        chk("mid_rst_tick", int'(period_tick), 0);
        chk("mid_rst_peak", int'(peak), 0);
        chk("mid_rst_trough", int'(trough), 0);
        chk("mid_rst_dir", int'(dir_up), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_dir = 1'b1;
        m_duty = 0;
        idle(3);
        start(4); period(2, 1); period(4, 0); idle(20);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
